// File: rtl/easyaxi_slv_rd_pkg.sv
// rtl/easyaxi_slv_rd_pkg.sv - shared encodings for the AXI read slave
package easyaxi_slv_rd_pkg;

    localparam logic [1:0] RRESP_OKAY    = 2'b00;
    localparam int         AXI_LEN_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/easyaxi_fifo.sv
// rtl/easyaxi_fifo.sv - in-order FIFO with registered occupancy count
module easyaxi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Status comes from the registered count, so a same-cycle pop never frees a slot early.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// rtl/easyaxi_slv_rd.sv - AXI read slave returning beat addresses as read data
module easyaxi_slv_rd
    import easyaxi_slv_rd_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int OST_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      axi_slv_arvalid,
    output logic                      axi_slv_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slv_araddr,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slv_arid,
    input  logic [7:0]                axi_slv_arlen,
    output logic                      axi_slv_rvalid,
    input  logic                      axi_slv_rready,
    output logic [AXI_DATA_WIDTH-1:0] axi_slv_rdata,
    output logic [AXI_ID_WIDTH-1:0]   axi_slv_rid,
    output logic [1:0]                axi_slv_rresp,
    output logic                      axi_slv_rlast
);

    localparam int ENTRY_W = AXI_ADDR_WIDTH + AXI_ID_WIDTH + AXI_LEN_WIDTH;
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

    rd_state_t                  state;
    logic                       ready_q;
    logic [AXI_ADDR_WIDTH-1:0]  cur_addr;
    logic [AXI_ADDR_WIDTH-1:0]  next_addr;
    logic [AXI_LEN_WIDTH-1:0]   len_q;
    logic [AXI_LEN_WIDTH-1:0]   beat_cnt;

    logic                       fifo_push;
    logic                       fifo_pop;
    logic [ENTRY_W-1:0]         fifo_din;
    logic [ENTRY_W-1:0]         fifo_dout;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(OST_DEPTH):0] fifo_count;
    logic                       unused_count;

    logic [AXI_ADDR_WIDTH-1:0]  head_addr;
    logic [AXI_ID_WIDTH-1:0]    head_id;
    logic [AXI_LEN_WIDTH-1:0]   head_len;
    logic                       beat_fire;

    // ready_q keeps arready low until the first edge after reset release.
    assign axi_slv_arready = enable & ready_q & ~fifo_full;
    assign axi_slv_rresp   = RRESP_OKAY;

    assign fifo_push = axi_slv_arvalid & axi_slv_arready;
    assign fifo_din  = {axi_slv_araddr, axi_slv_arid, axi_slv_arlen};
    assign fifo_pop  = (state == ST_IDLE) & enable & ~fifo_empty;
    assign {head_addr, head_id, head_len} = fifo_dout;

    assign beat_fire    = axi_slv_rvalid & axi_slv_rready;
    assign next_addr    = cur_addr + BEAT_BYTES;
    assign unused_count = ^fifo_count;

    easyaxi_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OST_DEPTH)
    ) u_ar_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            ready_q        <= 1'b0;
            cur_addr       <= '0;
            len_q          <= '0;
            beat_cnt       <= '0;
            axi_slv_rvalid <= 1'b0;
            axi_slv_rdata  <= '0;
            axi_slv_rid    <= '0;
            axi_slv_rlast  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state          <= ST_BURST;
                        cur_addr       <= head_addr;
                        len_q          <= head_len;
                        beat_cnt       <= '0;
                        axi_slv_rvalid <= 1'b1;
                        axi_slv_rdata  <= AXI_DATA_WIDTH'(head_addr);
                        axi_slv_rid    <= head_id;
                        axi_slv_rlast  <= (head_len == '0);
                    end
                end
                ST_BURST: begin
                    // Beat outputs only move on a handshake, so they hold through stalls.
                    if (beat_fire) begin
                        if (axi_slv_rlast) begin
                            state          <= ST_IDLE;
                            axi_slv_rvalid <= 1'b0;
                            axi_slv_rlast  <= 1'b0;
                        end else begin
                            cur_addr      <= next_addr;
                            beat_cnt      <= beat_cnt + AXI_LEN_WIDTH'(1);
                            axi_slv_rdata <= AXI_DATA_WIDTH'(next_addr);
                            axi_slv_rlast <= ((beat_cnt + AXI_LEN_WIDTH'(1)) == len_q);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
